// File: rtl/ball_locator.sv
// ball_locator: bounding box of ball pixels per frame -> centre x/y, per-axis lost flags, last good coordinates.
// Latency: outputs and frame_done update 2 clk_50M cycles after the vsync_in rising edge, then hold for the frame.
// Backpressure: none, free-running pixel stream. BALL_LOC_LOST_DEBOUNCE_EN adds per-axis lost-flag debounce.
module ball_locator #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MIN_PIXELS  = 16,
    parameter int MAX_SPAN    = 128,
    parameter int LOST_FRAMES = 3
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic        pix_valid,
    input  logic        pix_hit,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        lost_x,
    output logic        lost_y,
    output logic [10:0] lost_coordinate_x,
    output logic [10:0] lost_coordinate_y,
    output logic        frame_done
);
    typedef enum logic [1:0] {SYNC, ACC, CALC} state_t;

    localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
    localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);
    localparam logic [11:0] SPAN_X  = 12'(MAX_SPAN);
    localparam logic [10:0] SPAN_Y  = 11'(MAX_SPAN);
    localparam logic [11:0] X_RST   = 12'(H_ACTIVE / 2);
    localparam logic [10:0] Y_RST   = 11'(V_ACTIVE / 2);
    localparam logic [10:0] LCX_RST = 11'(H_ACTIVE / 2);

    state_t      state, state_nxt;
    logic        vs_d, hr_d;
    logic        vs_rise, hr_fall;
    logic        hit_ok, acc_en, calc_en, clr_frame;
    logic [11:0] col;
    logic [10:0] row;
    logic [11:0] min_x, max_x;
    logic [10:0] min_y, max_y;
    logic [19:0] hit_cnt;

    logic [12:0] sum_x;
    logic [11:0] sum_y;
    logic [11:0] cx, span_x;
    logic [10:0] cy, span_y;
    logic        valid, bad_x, bad_y;

    assign vs_rise = vsync_in & ~vs_d;
    assign hr_fall = ~href_in & hr_d;
    assign hit_ok  = pix_valid & pix_hit & href_in & (col < H_LIM) & (row < V_LIM);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            vs_d  <= 1'b0;
            hr_d  <= 1'b0;
            state <= SYNC;
        end else begin
            vs_d  <= vsync_in;
            hr_d  <= href_in;
            state <= state_nxt;
        end
    end

    // SYNC exit clears like a frame end so the partial frame after reset never reaches CALC.
    always_comb begin
        state_nxt = state;
        acc_en    = 1'b0;
        calc_en   = 1'b0;
        clr_frame = 1'b0;
        case (state)
            SYNC: begin
                if (vs_rise) begin
                    state_nxt = ACC;
                    clr_frame = 1'b1;
                end
            end
            ACC: begin
                acc_en = hit_ok;
                if (vs_rise) state_nxt = CALC;
            end
            CALC: begin
                calc_en   = 1'b1;
                clr_frame = 1'b1;
                state_nxt = ACC;
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            if (hr_fall)
                col <= '0;
            else if (href_in && pix_valid && col != '1)
                col <= col + 12'd1;

            if (clr_frame)
                row <= '0;
            else if (hr_fall && row != '1)
                row <= row + 11'd1;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset || clr_frame) begin
            min_x   <= '1;
            max_x   <= '0;
            min_y   <= '1;
            max_y   <= '0;
            hit_cnt <= '0;
        end else if (acc_en) begin
            if (col < min_x) min_x <= col;
            if (col > max_x) max_x <= col;
            if (row < min_y) min_y <= row;
            if (row > max_y) max_y <= row;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 20'd1;
        end
    end

    // Sums are one bit wider than the bounds so the centre cannot wrap.
    assign sum_x  = {1'b0, min_x} + {1'b0, max_x};
    assign sum_y  = {1'b0, min_y} + {1'b0, max_y};
    assign cx     = 12'(sum_x >> 1);
    assign cy     = 11'(sum_y >> 1);
    assign span_x = max_x - min_x;
    assign span_y = max_y - min_y;
    assign valid  = (hit_cnt >= MIN_CNT);
    assign bad_x  = ~valid | (span_x > SPAN_X);
    assign bad_y  = ~valid | (span_y > SPAN_Y);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            x                 <= X_RST;
            y                 <= Y_RST;
            lost_coordinate_x <= LCX_RST;
            lost_coordinate_y <= Y_RST;
            frame_done        <= 1'b0;
        end else begin
            frame_done <= calc_en;
            if (calc_en && !bad_x) begin
                x                 <= cx;
                lost_coordinate_x <= cx[10:0];
            end
            if (calc_en && !bad_y) begin
                y                 <= cy;
                lost_coordinate_y <= cy;
            end
        end
    end

`ifdef BALL_LOC_LOST_DEBOUNCE_EN
    localparam int MW = $clog2(LOST_FRAMES + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(LOST_FRAMES);

    logic [MW-1:0] miss_x, miss_y;

    // Counters start saturated so both axes report lost until a good frame arrives.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            miss_x <= MISS_MAX;
            miss_y <= MISS_MAX;
        end else if (calc_en) begin
            if (!bad_x)
                miss_x <= '0;
            else if (miss_x != MISS_MAX)
                miss_x <= miss_x + MW'(1);
            if (!bad_y)
                miss_y <= '0;
            else if (miss_y != MISS_MAX)
                miss_y <= miss_y + MW'(1);
        end
    end

    assign lost_x = (miss_x == MISS_MAX);
    assign lost_y = (miss_y == MISS_MAX);
`else
    logic lost_x_q, lost_y_q;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            lost_x_q <= 1'b1;
            lost_y_q <= 1'b1;
        end else if (calc_en) begin
            lost_x_q <= bad_x;
            lost_y_q <= bad_y;
        end
    end

    assign lost_x = lost_x_q;
    assign lost_y = lost_y_q;
`endif

endmodule

// File: tb/tb_ball_locator.sv
// Bench for ball_locator: randomized pixel frames checked against a bounding-box reference model.
module tb_ball_locator;
    localparam int H    = 640;
    localparam int V    = 480;
    localparam int MINP = 16;
    localparam int SPAN = 128;
    localparam int LF   = 3;

    logic        clk_50M = 1'b0;
    logic        reset, vsync_in, href_in, pix_valid, pix_hit;
    logic [11:0] x;
    logic [10:0] y, lcx, lcy;
    logic        lost_x, lost_y, frame_done;

    int n_chk = 0;
    int n_fail = 0;

    bit hitmap[int];
    int rowlast[int];

    int ex, ey, elcx, elcy;
    bit elx, ely;
`ifdef BALL_LOC_LOST_DEBOUNCE_EN
    int emx, emy;
`endif

    always #10 clk_50M = ~clk_50M;

    ball_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP), .MAX_SPAN(SPAN), .LOST_FRAMES(LF)) dut (
        .clk_50M(clk_50M), .reset(reset), .vsync_in(vsync_in), .href_in(href_in),
        .pix_valid(pix_valid), .pix_hit(pix_hit), .x(x), .y(y), .lost_x(lost_x), .lost_y(lost_y),
        .lost_coordinate_x(lcx), .lost_coordinate_y(lcy), .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic clear_frame();
        hitmap.delete();
        rowlast.delete();
    endtask

    task automatic add_hit(input int r, input int c);
        hitmap[r * 4096 + c] = 1'b1;
        if (!rowlast.exists(r) || rowlast[r] < c) rowlast[r] = c;
    endtask

    task automatic add_rect(input int r0, input int r1, input int c0, input int c1, input int fill_pct);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                if ($urandom_range(1, 100) <= fill_pct) add_hit(r, c);
    endtask

    task automatic model_reset();
        ex = H / 2; ey = V / 2; elcx = H / 2; elcy = V / 2;
        elx = 1'b1; ely = 1'b1;
`ifdef BALL_LOC_LOST_DEBOUNCE_EN
        emx = LF; emy = LF;
`endif
    endtask

    // Frame evaluation straight from the rules: bounding box of in-window hits.
    task automatic model_frame();
        int n, mnx, mxx, mny, mxy, r, c;
        bit ok, bx, by;
        n = 0; mnx = 4095; mxx = 0; mny = 2047; mxy = 0;
        foreach (hitmap[k]) begin
            r = k / 4096;
            c = k % 4096;
            if (c < H && r < V) begin
                n++;
                if (c < mnx) mnx = c;
                if (c > mxx) mxx = c;
                if (r < mny) mny = r;
                if (r > mxy) mxy = r;
            end
        end
        ok = (n >= MINP);
        bx = !ok || (mxx - mnx > SPAN);
        by = !ok || (mxy - mny > SPAN);
        if (!bx) begin ex = (mnx + mxx) / 2; elcx = ex; end
        if (!by) begin ey = (mny + mxy) / 2; elcy = ey; end
`ifdef BALL_LOC_LOST_DEBOUNCE_EN
        emx = bx ? ((emx < LF) ? emx + 1 : LF) : 0;
        emy = by ? ((emy < LF) ? emy + 1 : LF) : 0;
        elx = (emx == LF);
        ely = (emy == LF);
`else
        elx = bx;
        ely = by;
`endif
    endtask

    // Drives lines 0..last hit row; with merge the final hit pixel shares its cycle with the vsync rise.
    task automatic run_rows(input bit merge);
        int maxr;
        maxr = -1;
        foreach (rowlast[r]) if (r > maxr) maxr = r;
        for (int r = 0; r <= maxr; r++) begin
            href_in = 1'b1;
            if (rowlast.exists(r)) begin
                for (int c = 0; c <= rowlast[r]; c++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        pix_valid = 1'b0;
                        pix_hit = 1'($urandom_range(0, 1));
                        tick();
                    end
                    pix_valid = 1'b1;
                    pix_hit = hitmap.exists(r * 4096 + c);
                    if (merge && r == maxr && c == rowlast[r]) begin
                        vsync_in = 1'b1;
                        return;
                    end
                    tick();
                end
            end else begin
                pix_valid = 1'b0;
                tick();
            end
            href_in = 1'b0;
            pix_valid = 1'($urandom_range(0, 1));
            pix_hit = 1'($urandom_range(0, 1));
            tick();
            pix_valid = 1'b0;
            pix_hit = 1'b0;
        end
    endtask

    task automatic end_frame(input string tag, input bit merged);
        bit d0, d1, d2;
        if (!merged) begin
            href_in = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0;
            tick(); tick();
            vsync_in = 1'b1;
        end
        model_frame();
        @(posedge clk_50M);
        #1;
        href_in = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0;
        @(negedge clk_50M); d0 = frame_done;
        @(negedge clk_50M); d1 = frame_done;
        n_chk++;
        if (d0 !== 1'b0 || d1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_done timing: got %b,%b at edge+1,+2, expected 0,1", tag, d0, d1);
        end
        n_chk++;
        if (x !== ex[11:0]) begin n_fail++; $display("FAIL %s x: got %0d expected %0d", tag, x, ex); end
        n_chk++;
        if (y !== ey[10:0]) begin n_fail++; $display("FAIL %s y: got %0d expected %0d", tag, y, ey); end
        n_chk++;
        if (lost_x !== elx) begin n_fail++; $display("FAIL %s lost_x: got %b expected %b", tag, lost_x, elx); end
        n_chk++;
        if (lost_y !== ely) begin n_fail++; $display("FAIL %s lost_y: got %b expected %b", tag, lost_y, ely); end
        n_chk++;
        if (lcx !== elcx[10:0]) begin n_fail++; $display("FAIL %s lost_coordinate_x: got %0d expected %0d", tag, lcx, elcx); end
        n_chk++;
        if (lcy !== elcy[10:0]) begin n_fail++; $display("FAIL %s lost_coordinate_y: got %0d expected %0d", tag, lcy, elcy); end
        @(negedge clk_50M); d2 = frame_done;
        n_chk++;
        if (d2 !== 1'b0) begin n_fail++; $display("FAIL %s frame_done width: got %b at edge+3 expected 0", tag, d2); end
        tick(); tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bit seen;
        reset = 1'b1; vsync_in = 1'b0; href_in = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0;
        model_reset();
        tick(); tick();
        @(negedge clk_50M);
        n_chk++;
        if (x !== ex[11:0] || y !== ey[10:0]) begin
            n_fail++; $display("FAIL reset x/y: got %0d/%0d expected %0d/%0d", x, y, ex, ey);
        end
        n_chk++;
        if (lost_x !== 1'b1 || lost_y !== 1'b1) begin
            n_fail++; $display("FAIL reset lost: got %b%b expected 11", lost_x, lost_y);
        end
        n_chk++;
        if (lcx !== elcx[10:0] || lcy !== elcy[10:0]) begin
            n_fail++; $display("FAIL reset lost_coordinate: got %0d/%0d expected %0d/%0d", lcx, lcy, elcx, elcy);
        end
        n_chk++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
        tick();
        reset = 1'b0;
        tick();
        seen = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50M);
            if (frame_done) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL sync_edge: got frame_done=1 expected 0 on first vsync"); end
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic test_empty_frame();
        clear_frame();
        run_rows(1'b0);
        end_frame("empty", 1'b0);
    endtask

    task automatic test_square();
        clear_frame();
        add_rect(50, 59, 100, 109, 100);
        run_rows(1'b0);
        end_frame("square", 1'b0);
    endtask

    task automatic test_few_pixels();
        clear_frame();
        add_rect(80, 81, 30, 33, 100);
        run_rows(1'b0);
        end_frame("few_pixels", 1'b0);
    endtask

    task automatic test_span();
        clear_frame();
        add_rect(70, 70, 10, 19, 100);
        add_rect(70, 70, 291, 300, 100);
        run_rows(1'b0);
        end_frame("span_290", 1'b0);
        clear_frame();
        add_rect(72, 72, 10, 19, 100);
        add_rect(72, 72, 129, 138, 100);
        run_rows(1'b0);
        end_frame("span_128", 1'b0);
    endtask

    task automatic test_bounds();
        clear_frame();
        add_rect(20, 20, 640, 645, 100);
        add_rect(21, 24, 5, 8, 100);
        add_hit(480, 3);
        add_hit(481, 1);
        run_rows(1'b0);
        end_frame("bounds", 1'b0);
    endtask

    task automatic test_vsync_same_cycle();
        clear_frame();
        add_rect(30, 33, 50, 54, 100);
        add_hit(33, 90);
        run_rows(1'b1);
        end_frame("vsync_last_pixel", 1'b1);
    endtask

    task automatic test_lost_sequence();
        clear_frame(); add_rect(40, 45, 60, 65, 100); run_rows(1'b0); end_frame("seq_good", 1'b0);
        for (int i = 0; i < 3; i++) begin
            clear_frame(); run_rows(1'b0); end_frame("seq_empty", 1'b0);
        end
        clear_frame(); add_rect(10, 14, 20, 24, 100); run_rows(1'b0); end_frame("seq_recover", 1'b0);
    endtask

    task automatic test_random();
        int r0, h, c0, w;
        for (int i = 0; i < 8; i++) begin
            clear_frame();
            r0 = $urandom_range(0, 200);
            h  = $urandom_range(1, 8);
            c0 = $urandom_range(0, 150);
            w  = $urandom_range(1, (i % 3 == 0) ? 160 : 40);
            add_rect(r0, r0 + h - 1, c0, c0 + w - 1, 75);
            if (i % 4 == 1) add_hit(r0 + 140, c0);
            run_rows(1'b0);
            end_frame("random", 1'b0);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        clear_frame();
        add_rect(100, 101, 200, 203, 100);
        run_rows(1'b0);
        href_in = 1'b1; pix_valid = 1'b1; pix_hit = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        @(negedge clk_50M);
        n_chk++;
        if (x !== ex[11:0] || y !== ey[10:0] || lost_x !== 1'b1 || lost_y !== 1'b1) begin
            n_fail++; $display("FAIL midreset state: got x=%0d y=%0d lost=%b%b expected %0d %0d 11", x, y, lost_x, lost_y, ex, ey);
        end
        tick();
        href_in = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0;
        tick();
        clear_frame();
        add_rect(0, 3, 10, 30, 100);
        run_rows(1'b0);
        tick();
        seen = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50M);
            if (frame_done) seen = 1'b1;
        end
        n_chk++;
        if (seen || x !== ex[11:0]) begin
            n_fail++; $display("FAIL midreset discard: got frame_done_seen=%b x=%0d expected 0 and %0d", seen, x, ex);
        end
        tick();
        vsync_in = 1'b0;
        tick();
        clear_frame();
        add_rect(296, 304, 396, 404, 100);
        run_rows(1'b0);
        end_frame("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_square();
        test_few_pixels();
        test_span();
        test_bounds();
        test_vsync_same_cycle();
        test_lost_sequence();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
